// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the loader FSM state
// encoding, the header (word count) width and the word/byte geometry used by
// both the loader top level and its byte assembler.
package imem_loader_pkg;

  localparam int HDR_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    FLUSH  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler
// Packs a stream of accepted bytes into big-endian words. The first byte of a
// word lands in the most significant lane. When the last byte of a word is
// accepted, the finished word is registered and o_word_valid pulses for one
// cycle; o_word holds its value until the next word completes.
//
// Ports:
//   i_clk, i_reset    clock and synchronous active-high reset
//   i_clear           restart the byte counter at lane 0 (new load)
//   i_byte_valid      a byte is accepted this cycle
//   i_byte            accepted byte
//   o_last_byte       the byte currently offered would complete a word
//   o_word_valid      one-cycle pulse: o_word holds a newly completed word
//   o_word            last completed word
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_last_byte,
  output logic                  o_word_valid,
  output logic [WORD_WIDTH-1:0] o_word
);

  localparam logic [BYTE_IDX_W-1:0] LP_LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Only the leading bytes need storage; the final byte is merged directly.
  logic [WORD_WIDTH-BYTE_WIDTH-1:0] r_shift;
  logic [BYTE_IDX_W-1:0]            r_byte_idx;
  logic                             r_word_valid;
  logic [WORD_WIDTH-1:0]            r_word;

  assign o_last_byte  = (r_byte_idx == LP_LAST_IDX);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  // Byte shift register, lane counter and completed-word register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else if (i_clear) begin
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_word_valid <= 1'b0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[WORD_WIDTH-2*BYTE_WIDTH-1:0], i_byte};
      if (o_last_byte) begin
        r_word       <= {r_shift, i_byte};
        r_word_valid <= 1'b1;
        r_byte_idx   <= '0;
      end else begin
        r_word_valid <= 1'b0;
        r_byte_idx   <= r_byte_idx + BYTE_IDX_W'(1);
      end
    end else begin
      r_word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads a program into instruction memory from a byte stream while holding
// the processor core in reset. Stream format: 16-bit big-endian word count N,
// then N big-endian 32-bit words written from address 0 upward. N == 0 or N
// larger than the memory depth is rejected (error latched until next start).
// After the final write the core is released (cpu_reset low, done high).
// A start while running reloads the memory from address 0.
//
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_start             one-cycle load request (honoured in IDLE, RUN, ERR)
//   i_in_valid/i_in_data  byte stream; consumed when valid and ready
//   o_in_ready          loader accepts a byte this cycle
//   o_imem_we           one-cycle write strobe per assembled word
//   o_imem_addr         word-aligned byte address of the write
//   o_imem_wdata        assembled instruction word
//   o_cpu_reset         holds the core in reset (low only in RUN)
//   o_done              program running
//   o_error             rejected header latched
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_in_valid,
  input  logic [BYTE_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_imem_we,
  output logic [31:0]           o_imem_addr,
  output logic [WORD_WIDTH-1:0] o_imem_wdata,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error
);

  // One extra bit so a full-depth count (2**ADDR_WIDTH) is representable.
  localparam logic [HDR_WIDTH:0] LP_DEPTH = (HDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

  state_e                w_next;
  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [HDR_WIDTH-1:0]  r_n;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [31:0]           r_imem_addr;

  logic                  w_accept;
  logic                  w_data_accept;
  logic                  w_hdr_done;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_bad_count;
  logic [HDR_WIDTH-1:0]  w_n;

  assign w_accept      = i_in_valid && r_in_ready;
  assign w_data_accept = w_accept && (r_state == DATA);
  assign w_hdr_done    = w_accept && (r_state == HDR_LO);
  // Full count as it will be once the low header byte is taken this cycle.
  assign w_n           = {r_n[HDR_WIDTH-1:BYTE_WIDTH], i_in_data};
  assign w_bad_count   = (w_n == HDR_WIDTH'(0)) || ({1'b0, w_n} > LP_DEPTH);
  assign w_last_word   = (HDR_WIDTH'(r_word_idx) == (r_n - HDR_WIDTH'(1)));

  byte_assembler u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_hdr_done),
    .i_byte_valid (w_data_accept),
    .i_byte       (i_in_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (o_imem_we),
    .o_word       (o_imem_wdata)
  );

  // Next-state logic for the load sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = HDR_HI;
        else         w_next = IDLE;
      end
      HDR_HI: begin
        if (w_accept) w_next = HDR_LO;
        else          w_next = HDR_HI;
      end
      HDR_LO: begin
        if (w_accept) begin
          if (w_bad_count) w_next = ERR;
          else             w_next = DATA;
        end else begin
          w_next = HDR_LO;
        end
      end
      DATA: begin
        if (w_data_accept && w_last_byte && w_last_word) w_next = FLUSH;
        else                                             w_next = DATA;
      end
      FLUSH: begin
        // The final write strobe is on the bus during this state.
        w_next = RUN;
      end
      RUN: begin
        if (i_start) w_next = HDR_HI;
        else         w_next = RUN;
      end
      ERR: begin
        if (i_start) w_next = HDR_HI;
        else         w_next = ERR;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register; status outputs are registered from the next state so they
  // change in the same cycle as the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == HDR_HI) || (w_next == HDR_LO) || (w_next == DATA);
      r_cpu_reset <= (w_next != RUN);
      r_done      <= (w_next == RUN);
      r_error     <= (w_next == ERR);
    end
  end

  // Header count, word index and write address. The address is captured on
  // the same edge the assembler registers the word, so both appear together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_n         <= '0;
      r_word_idx  <= '0;
      r_imem_addr <= '0;
    end else begin
      if (w_accept && (r_state == HDR_HI)) begin
        r_n[HDR_WIDTH-1:BYTE_WIDTH] <= i_in_data;
      end
      if (w_hdr_done) begin
        r_n[BYTE_WIDTH-1:0] <= i_in_data;
        r_word_idx          <= '0;
      end
      if (w_data_accept && w_last_byte) begin
        r_imem_addr <= 32'({r_word_idx, 2'b00});
        r_word_idx  <= r_word_idx + ADDR_WIDTH'(1);
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_imem_addr = r_imem_addr;
  assign o_cpu_reset = r_cpu_reset;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader: drives byte streams on the falling edge,
// collects write strobes shortly after each rising edge, and compares against
// hand-computed words and addresses.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_reset  (o_cpu_reset),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Write monitor, sampling shortly after each rising edge.
  always @(posedge i_clk) begin
    #2;
    cyc++;
    if (o_imem_we) begin
      wr_addr.push_back(o_imem_addr);
      wr_data.push_back(o_imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Offer one byte; returns on the falling edge after it was consumed.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    i_in_valid = 1'b1;
    i_in_data  = b;
    while (!o_in_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) check("handshake_timeout", {31'd0, o_in_ready}, 32'd1);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    if (gap) @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  initial begin
    logic [31:0] w;
    bit          all_ok;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    check("rst_in_ready",  {31'd0, o_in_ready},  32'd0);
    check("rst_we",        {31'd0, o_imem_we},   32'd0);
    check("rst_done",      {31'd0, o_done},      32'd0);
    check("rst_error",     {31'd0, o_error},     32'd0);
    check("rst_addr",      o_imem_addr,          32'h0);
    check("rst_wdata",     o_imem_wdata,         32'h0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Two-word load, back-to-back bytes.
    clear_log();
    pulse_start();
    check("load2_ready", {31'd0, o_in_ready}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'h8C090004, 1'b0);
    check("load2_flush_we",    {31'd0, o_imem_we},   32'd1);
    check("load2_flush_ready", {31'd0, o_in_ready},  32'd0);
    check("load2_flush_cpurst",{31'd0, o_cpu_reset}, 32'd1);
    @(negedge i_clk);
    check("load2_cpurst_fall", {31'd0, o_cpu_reset}, 32'd0);
    check("load2_done",        {31'd0, o_done},      32'd1);
    check("load2_hold_addr",   o_imem_addr,          32'h4);
    check("load2_hold_data",   o_imem_wdata,         32'h8C090004);
    check("load2_nwr",         wr_addr.size(),       32'd2);
    if (wr_addr.size() == 2) begin
      check("load2_addr0", wr_addr[0], 32'h0);
      check("load2_data0", wr_data[0], 32'h20080005);
      check("load2_addr1", wr_addr[1], 32'h4);
      check("load2_data1", wr_data[1], 32'h8C090004);
      check("load2_spacing", wr_cyc[1] - wr_cyc[0], 32'd4);
    end

    // Zero-count header from RUN: reload request, then rejection.
    clear_log();
    pulse_start();
    check("reload_cpurst", {31'd0, o_cpu_reset}, 32'd1);
    check("reload_done",   {31'd0, o_done},      32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("zero_error",  {31'd0, o_error},     32'd1);
    check("zero_cpurst", {31'd0, o_cpu_reset}, 32'd1);
    check("zero_ready",  {31'd0, o_in_ready},  32'd0);
    repeat (2) @(negedge i_clk);
    check("zero_nwr", wr_addr.size(), 32'd0);
    pulse_start();
    check("err_cleared", {31'd0, o_error}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    @(negedge i_clk);
    check("after_err_done", {31'd0, o_done}, 32'd1);
    check("after_err_nwr",  wr_addr.size(),  32'd1);
    if (wr_addr.size() == 1) check("after_err_data", wr_data[0], 32'hDEADBEEF);

    // Oversize header, then full-depth load.
    clear_log();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("n257_error", {31'd0, o_error}, 32'd1);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
      send_word(w, 1'b0);
    end
    @(negedge i_clk);
    check("n256_error", {31'd0, o_error}, 32'd0);
    check("n256_done",  {31'd0, o_done},  32'd1);
    check("n256_nwr",   wr_addr.size(),   32'd256);
    if (wr_addr.size() == 256) begin
      check("n256_last_addr", wr_addr[255], 32'h3FC);
      check("n256_last_data", wr_data[255], 32'hFF005A3C);
      all_ok = 1'b1;
      for (int i = 0; i < 256; i++) begin
        w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== w) all_ok = 1'b0;
      end
      check("n256_all_words", {31'd0, all_ok}, 32'd1);
    end

    // Gapped stream: valid every other cycle.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h20080005, 1'b1);
    send_word(32'h8C090004, 1'b1);
    @(negedge i_clk);
    check("gap_done", {31'd0, o_done}, 32'd1);
    check("gap_nwr",  wr_addr.size(),  32'd2);
    if (wr_addr.size() == 2) begin
      check("gap_addr0", wr_addr[0], 32'h0);
      check("gap_data0", wr_data[0], 32'h20080005);
      check("gap_addr1", wr_addr[1], 32'h4);
      check("gap_data1", wr_data[1], 32'h8C090004);
    end
    // Bytes offered while not ready are ignored.
    i_in_valid = 1'b1;
    i_in_data  = 8'hAA;
    repeat (3) @(negedge i_clk);
    i_in_valid = 1'b0;
    check("run_ignore_nwr",  wr_addr.size(),  32'd2);
    check("run_ignore_done", {31'd0, o_done}, 32'd1);

    // Reset mid-load after six data bytes.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    i_reset    = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = 8'h77;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("midrst_ready",  {31'd0, o_in_ready},  32'd0);
    check("midrst_cpurst", {31'd0, o_cpu_reset}, 32'd1);
    check("midrst_we",     {31'd0, o_imem_we},   32'd0);
    repeat (3) @(negedge i_clk);
    i_in_valid = 1'b0;
    check("midrst_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) check("midrst_data0", wr_data[0], 32'h11223344);

    // Reset dominates a simultaneous start.
    i_reset = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_start = 1'b0;
    check("rst_vs_start_ready", {31'd0, o_in_ready}, 32'd0);
    @(negedge i_clk);
    check("rst_vs_start_idle", {31'd0, o_in_ready}, 32'd0);

    // Start mid-word in DATA has no effect.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    i_start = 1'b1;
    send_byte(8'h03, 1'b0);
    i_start = 1'b0;
    send_byte(8'h04, 1'b0);
    send_word(32'h05060708, 1'b0);
    @(negedge i_clk);
    check("midstart_done", {31'd0, o_done}, 32'd1);
    check("midstart_nwr",  wr_addr.size(),  32'd2);
    if (wr_addr.size() == 2) begin
      check("midstart_data0", wr_data[0], 32'h01020304);
      check("midstart_addr1", wr_addr[1], 32'h4);
      check("midstart_data1", wr_data[1], 32'h05060708);
    end

    // Reload from RUN with a single all-ones word.
    clear_log();
    pulse_start();
    check("reload1_cpurst", {31'd0, o_cpu_reset}, 32'd1);
    check("reload1_done",   {31'd0, o_done},      32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0);
    check("reload1_we",   {31'd0, o_imem_we}, 32'd1);
    check("reload1_addr", o_imem_addr,        32'h0);
    check("reload1_data", o_imem_wdata,       32'hFFFFFFFF);
    @(negedge i_clk);
    check("reload1_run",    {31'd0, o_done},      32'd1);
    check("reload1_cpurel", {31'd0, o_cpu_reset}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, log2 of instruction-memory depth in words (256 words).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word written, word-aligned.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_reset  output  1  held high to keep the processor core in reset.
REQ-012 done  output  1  high while the loaded program runs.
REQ-013 error  output  1  high while a rejected header is latched.

Function
REQ-014 The FSM SHALL have states IDLE, HDR_HI, HDR_LO, DATA, FLUSH, RUN and ERR.
REQ-015 A byte SHALL be consumed only on a cycle where in_valid && in_ready; bytes presented while in_ready=0 SHALL be ignored, not consumed.
REQ-016 in_ready SHALL be 1 exactly in HDR_HI, HDR_LO and DATA.
REQ-017 IDLE->HDR_HI on start; RUN->HDR_HI on start (reload); ERR->HDR_HI on start, clearing error.
REQ-018 start SHALL be ignored in HDR_HI, HDR_LO, DATA and FLUSH.
REQ-019 HDR_HI consumes the word count N[15:8]; HDR_LO consumes N[7:0] (big-endian).
REQ-020 After HDR_LO, N==0 or N>2**ADDR_WIDTH SHALL go to ERR; otherwise the FSM goes to DATA with word_idx=0 and byte_idx=0.
REQ-021 DATA SHALL assemble bytes big-endian: the first byte goes to wdata[31:24] and the fourth to wdata[7:0].
REQ-022 The cycle after the fourth byte is consumed, imem_we=1 for exactly one cycle, with imem_wdata the assembled word and imem_addr = {word_idx,2'b00} zero-extended to 32 bits.
REQ-023 word_idx SHALL increment after each write. byte_idx SHALL wrap 3->0.
REQ-024 When the fourth byte of word N-1 is consumed, the FSM goes to FLUSH (in_ready=0), where the final imem_we is issued; FLUSH->RUN unconditionally.
REQ-025 Back-to-back valid bytes SHALL sustain one byte per cycle. A word write SHALL overlap acceptance of the next word's first byte.
REQ-026 cpu_reset SHALL be registered and equal 1 in every state except RUN.
REQ-027 done = 1 exactly in RUN.
REQ-028 error = 1 exactly in ERR.
REQ-029 cpu_reset SHALL deassert the cycle after the final imem_we, never earlier.
REQ-030 On a reload from RUN, cpu_reset SHALL reassert in the cycle after start; instruction memory SHALL be overwritten from address 0.
REQ-031 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-032 On reset: state=IDLE, cpu_reset=1, in_ready=0, imem_we=0, done=0, error=0, imem_addr=0, imem_wdata=0, word_idx=0, byte_idx=0, N=0.
REQ-033 Reset asserted mid-load SHALL abort the load with no further imem_we; partially written memory is not restored.
REQ-034 Reset SHALL dominate a simultaneous start.

Structure
REQ-035 A shared package SHALL hold the state enumeration, the header width (16) and the bytes-per-word constant (4).
REQ-036 One sub-module, byte_assembler (shift register plus byte_idx counter, emits word_valid), SHALL be instantiated. The FSM, counters and header checks SHALL stay in imem_loader.

Verification
REQ-037 Load of two words: start; bytes 00 02 20 08 00 05 8C 09 00 04 -> imem_we at addr 0x0 data 0x20080005, then addr 0x4 data 0x8C090004; cpu_reset falls one cycle after the second write; done=1.
REQ-038 Header 00 00 -> ERR, error=1, cpu_reset=1, no imem_we. A subsequent start with a valid stream SHALL load normally and clear error.
REQ-039 Header 01 01 (N=257, ADDR_WIDTH=8) -> ERR; header 01 00 (N=256) -> 256 writes, last at addr 0x3FC.
REQ-040 in_valid toggled every other cycle during DATA -> identical words and addresses; no byte lost or duplicated.
REQ-041 Reset pulsed after 6 data bytes -> IDLE next cycle, imem_we stays 0, cpu_reset=1; start in DATA mid-word -> no effect on words written.
REQ-042 start in RUN -> cpu_reset=1 and done=0 the next cycle; a reload of N=1 word 0xFFFFFFFF writes addr 0x0, then returns to RUN.
